// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_if
// Description : Instruction-fetch interface. Consumes {excepttype, ce, pc}
//               from the PC generator and issues one SRAM-like fetch per PC.
//               It collects the returned instruction, presents it to ID as a
//               valid-tagged bundle, stalls PC/IF while the instruction is
//               outstanding, and cancels in-flight fetches on flush.
// Ports       : clk, rst (sync, active-low)      - clock / reset
//               stall[STALL_WD-1:0], flush        - pipeline control in
//               pc_to_ic_bus[64:0]                - {excepttype, ce, pc}
//               inst_sram_req/addr/addr_ok/data_ok/rdata - SRAM-like bus
//               if_to_id_bus[96:0]                - {valid, excepttype, pc, inst}
//               stallreq_if                       - stall request to PC/IF
// Config      : `define INST_ADDR_MAP_EN applies the fixed kseg0/kseg1
//               mapping to inst_sram_addr (buffered pc remains virtual).
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_if #(
  parameter int PC_TO_IC_WD = 65,
  parameter int IF_TO_ID_WD = 97,
  parameter int STALL_WD    = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_WD-1:0]    stall,
  input  logic                   flush,
  input  logic [PC_TO_IC_WD-1:0] pc_to_ic_bus,
  output logic                   inst_sram_req,
  output logic [31:0]            inst_sram_addr,
  input  logic                   inst_sram_addr_ok,
  input  logic                   inst_sram_data_ok,
  input  logic [31:0]            inst_sram_rdata,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   stallreq_if
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_CANCEL = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_buf_q, pc_buf_d;
  logic [31:0] exc_buf_q, exc_buf_d;

  // Input bus fields
  logic [31:0] in_exc;
  logic        in_ce;
  logic [31:0] in_pc;
  logic        adel;

  assign in_exc = pc_to_ic_bus[64:33];
  assign in_ce  = pc_to_ic_bus[32];
  assign in_pc  = pc_to_ic_bus[31:0];
  assign adel   = in_exc[16];

  // Only stall[1] matters to this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[STALL_WD-1:2], stall[0]};

  assign inst_sram_req = in_ce & ~flush & ~adel &
                         ((state_q == ST_IDLE) | (state_q == ST_REQ));

`ifdef INST_ADDR_MAP_EN
  // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) map onto the low 512 MB.
  always_comb begin
    inst_sram_addr = in_pc;
    if (in_pc[31:30] == 2'b10) begin
      inst_sram_addr = {3'b000, in_pc[28:0]};
    end
  end
`else
  assign inst_sram_addr = in_pc;
`endif

  // CANCEL keeps the PC frozen until the orphaned response has drained.
  assign stallreq_if = (in_ce & (state_q != ST_DONE)) | (state_q == ST_CANCEL);

  assign if_to_id_bus = (state_q == ST_DONE) ?
                        {1'b1, exc_buf_q, pc_buf_q, inst_q} : '0;

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    pc_buf_d  = pc_buf_q;
    exc_buf_d = exc_buf_q;

    case (state_q)
      ST_IDLE: begin
        if (!flush) begin
          if (in_ce && adel) begin
            // Address error: deliver the exception without touching the bus.
            state_d   = ST_DONE;
            inst_d    = 32'h0;
            pc_buf_d  = in_pc;
            exc_buf_d = in_exc;
          end else if (inst_sram_req && inst_sram_addr_ok) begin
            state_d = ST_WAIT;
          end else if (inst_sram_req) begin
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        // Request was never accepted, so dropping it owes no response.
        if (flush || !inst_sram_req) begin
          state_d = ST_IDLE;
        end else if (inst_sram_addr_ok) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (flush) begin
          // A response landing with the flush retires the outstanding fetch.
          state_d = inst_sram_data_ok ? ST_IDLE : ST_CANCEL;
        end else if (inst_sram_data_ok) begin
          state_d   = ST_DONE;
          inst_d    = inst_sram_rdata;
          pc_buf_d  = in_pc;
          exc_buf_d = in_exc;
        end
      end

      ST_DONE: begin
        if (flush) begin
          state_d   = ST_IDLE;
          inst_d    = 32'h0;
          pc_buf_d  = 32'h0;
          exc_buf_d = 32'h0;
        end else if (!stall[1]) begin
          state_d = ST_IDLE;
        end
      end

      ST_CANCEL: begin
        if (inst_sram_data_ok) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      inst_q    <= 32'h0;
      pc_buf_q  <= 32'h0;
      exc_buf_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      pc_buf_q  <= pc_buf_d;
      exc_buf_q <= exc_buf_d;
    end
  end

endmodule
`default_nettype wire
